// File: rtl/cnn_pkg.sv
// Shared CNN pipeline types and constants: pixel/address typedefs, receiver states and the
// byte-to-fixed-point conversion used to build the input LUT.
package cnn_pkg;

  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned FRAC_BITS   = 7;
  localparam int unsigned IMG_SIZE    = 28;
  localparam int unsigned IN_CHANNELS = 1;
  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int unsigned IF_SZ       = IMG_SIZE * IMG_SIZE * IN_CHANNELS;
  localparam int unsigned IF_AW       = $clog2(IF_SZ);

  typedef logic [IF_AW-1:0]             if_addr_t;
  typedef logic signed [DATA_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {HUNT, PIX, CHK} rx_state_t;

  // Rounded k/255 scaled to 2^frac: 0 -> 0, 255 -> 1.0.
  function automatic int unsigned u8_to_q(input int unsigned k, input int unsigned frac);
    return (k * (32'd1 << frac) + 32'd127) / 32'd255;
  endfunction

endpackage

// File: rtl/frame_rx_timeout.sv
// Inter-byte watchdog: reloads on kick or while disabled, counts down while enabled and raises
// tc on the cycle the count has run out with no kick pending.
module frame_rx_timeout #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic kick,
  output logic tc
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!en || kick) begin
      count_d = LOAD;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A byte arriving on the terminal cycle takes priority over the abort.
  assign tc = en && !kick && (count_q == '0);

endmodule

// File: rtl/frame_rx_loader.sv
// Framed host-packet receiver: sync byte, pixel bytes written to IFMAP as fixed point, checksum.
// Optional good/bad frame counters are built when FRAME_RX_STATS_EN is defined.
module frame_rx_loader #(
  parameter int unsigned DATA_WIDTH     = cnn_pkg::DATA_WIDTH,
  parameter int unsigned FRAC_BITS      = cnn_pkg::FRAC_BITS,
  parameter int unsigned IMG_SIZE       = cnn_pkg::IMG_SIZE,
  parameter int unsigned IN_CHANNELS    = cnn_pkg::IN_CHANNELS,
  parameter logic [7:0]  SYNC_BYTE      = cnn_pkg::SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  localparam int unsigned IF_SZ         = IMG_SIZE * IMG_SIZE * IN_CHANNELS,
  localparam int unsigned IF_AW         = $clog2(IF_SZ)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         rx_dv,
  input  logic [7:0]                   rx_byte,
  input  logic                         pipe_busy,
  output logic                         wr_en,
  output logic [IF_AW-1:0]             wr_addr,
  output logic signed [DATA_WIDTH-1:0] wr_data,
  output logic                         frame_loaded,
  output logic                         frame_err,
  output logic                         loading,
  output logic [15:0]                  good_cnt,
  output logic [15:0]                  bad_cnt
);

  import cnn_pkg::*;

  localparam logic [IF_AW-1:0] LAST_IDX = IF_AW'(IF_SZ - 1);

  logic signed [DATA_WIDTH-1:0] lut [256];

  for (genvar k = 0; k < 256; k++) begin : g_lut
    assign lut[k] = DATA_WIDTH'(u8_to_q(k, FRAC_BITS));
  end

  rx_state_t                    state_q, state_d;
  logic [IF_AW-1:0]             idx_q, idx_d;
  logic [7:0]                   sum_q, sum_d, sum_plus;
  logic                         wr_en_d, loaded_d, err_d;
  logic [IF_AW-1:0]             wr_addr_d;
  logic signed [DATA_WIDTH-1:0] wr_data_d;
  logic                         tmo;

  frame_rx_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q != HUNT),
    .kick    (rx_dv),
    .tc      (tmo)
  );

  assign sum_plus = sum_q + rx_byte;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    loaded_d  = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (rx_dv && rx_byte == SYNC_BYTE && !pipe_busy) begin
          state_d = PIX;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      PIX: begin
        // Sync-valued bytes here are ordinary pixels.
        if (rx_dv) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = lut[rx_byte];
          sum_d     = sum_plus;
          idx_d     = idx_q + IF_AW'(1);
          if (idx_q == LAST_IDX) begin
            state_d = CHK;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = HUNT;
        end
      end
      CHK: begin
        if (rx_dv) begin
          loaded_d = (sum_plus == 8'd0);
          err_d    = (sum_plus != 8'd0);
          state_d  = HUNT;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      idx_q        <= '0;
      sum_q        <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      frame_loaded <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      wr_en        <= wr_en_d;
      wr_addr      <= wr_addr_d;
      wr_data      <= wr_data_d;
      frame_loaded <= loaded_d;
      frame_err    <= err_d;
    end
  end

  assign loading = (state_q != HUNT);

`ifdef FRAME_RX_STATS_EN
  logic [15:0] good_q, bad_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      if (loaded_d && good_q != 16'hFFFF) good_q <= good_q + 16'd1;
      if (err_d && bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
    end
  end

  assign good_cnt = good_q;
  assign bad_cnt  = bad_q;
`else
  assign good_cnt = '0;
  assign bad_cnt  = '0;
`endif

endmodule
